// File: rtl/sdram_cmd_scheduler.sv
// rtl/sdram_cmd_scheduler.sv - init, periodic refresh and host arbitration sequencer
// Starts one SDRAM command-sequence generator at a time and waits for its done pulse.
module sdram_cmd_scheduler #(
  parameter int INIT_WAIT        = 200,
  parameter int REFRESH_INTERVAL = 780,
  parameter int NUM_INIT_REF     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_req,
  input  logic wr_req,
  input  logic seq_done,
  output logic pre_start,
  output logic ref_start,
  output logic mrs_start,
  output logic rd_start,
  output logic wr_start,
  output logic rd_ack,
  output logic wr_ack,
  output logic init_done,
  output logic busy,
  output logic ref_overrun
);

  localparam logic [2:0] WAIT_PWR = 3'd0;
  localparam logic [2:0] INIT_PRE = 3'd1;
  localparam logic [2:0] INIT_REF = 3'd2;
  localparam logic [2:0] INIT_MRS = 3'd3;
  localparam logic [2:0] IDLE     = 3'd4;
  localparam logic [2:0] REF      = 3'd5;
  localparam logic [2:0] READ     = 3'd6;
  localparam logic [2:0] WRITE    = 3'd7;

  localparam int WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam int TMR_W  = $clog2(REFRESH_INTERVAL);
  localparam int IREF_W = (NUM_INIT_REF > 1) ? $clog2(NUM_INIT_REF) : 1;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [IREF_W-1:0] IREF_LAST = IREF_W'(NUM_INIT_REF - 1);

  logic [2:0]        state, state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TMR_W-1:0]  timer;
  logic [IREF_W-1:0] iref_cnt;
  logic              issued, ref_pending, last_rd;
  logic              any_start, op_state, accept, wrap, host_rd, host_wr;

  assign any_start = pre_start | ref_start | mrs_start | rd_start | wr_start;
  assign op_state  = (state != WAIT_PWR) && (state != IDLE);
  // seq_done is only meaningful once the start pulse has gone by
  assign accept    = op_state & issued & ~any_start & seq_done;
  assign wrap      = init_done && (timer == TMR_LAST);
  assign host_rd   = rd_req & init_done;
  assign host_wr   = wr_req & init_done;
  assign rd_ack    = (state == READ) & accept;
  assign wr_ack    = (state == WRITE) & accept;

  always_comb begin
    state_nx = state;
    case (state)
      WAIT_PWR: if (wait_cnt == WAIT_LAST) state_nx = INIT_PRE;
      INIT_PRE: if (accept) state_nx = INIT_REF;
      INIT_REF: if (accept && iref_cnt == IREF_LAST) state_nx = INIT_MRS;
      INIT_MRS: if (accept) state_nx = IDLE;
      IDLE: begin
        if (ref_pending)          state_nx = REF;
        else if (host_rd && host_wr) state_nx = last_rd ? WRITE : READ;
        else if (host_rd)         state_nx = READ;
        else if (host_wr)         state_nx = WRITE;
      end
      default:  if (accept) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_PWR;
      wait_cnt    <= '0;
      timer       <= '0;
      iref_cnt    <= '0;
      issued      <= 1'b0;
      ref_pending <= 1'b0;
      last_rd     <= 1'b0;
      pre_start   <= 1'b0;
      ref_start   <= 1'b0;
      mrs_start   <= 1'b0;
      rd_start    <= 1'b0;
      wr_start    <= 1'b0;
      init_done   <= 1'b0;
      busy        <= 1'b0;
      ref_overrun <= 1'b0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx != IDLE);
      pre_start <= 1'b0;
      ref_start <= 1'b0;
      mrs_start <= 1'b0;
      rd_start  <= 1'b0;
      wr_start  <= 1'b0;

      if (state == WAIT_PWR) wait_cnt <= wait_cnt + WAIT_W'(1);

      if (op_state && !issued) begin
        issued <= 1'b1;
        case (state)
          INIT_PRE:           pre_start <= 1'b1;
          INIT_REF, REF:      ref_start <= 1'b1;
          INIT_MRS:           mrs_start <= 1'b1;
          READ:               rd_start  <= 1'b1;
          default:            wr_start  <= 1'b1;
        endcase
      end
      if (accept) issued <= 1'b0;

      if (state == INIT_REF && accept) iref_cnt <= iref_cnt + IREF_W'(1);
      if (state == INIT_MRS && accept) init_done <= 1'b1;

      if (!init_done || wrap) timer <= '0;
      else                    timer <= timer + TMR_W'(1);

      // a wrap in the same cycle as ref_start keeps the request alive
      if (wrap)           ref_pending <= 1'b1;
      else if (ref_start) ref_pending <= 1'b0;
      if (wrap && ref_pending) ref_overrun <= 1'b1;

      if (state == IDLE && state_nx == READ)  last_rd <= 1'b1;
      if (state == IDLE && state_nx == WRITE) last_rd <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// tb/tb_sdram_cmd_scheduler.sv - randomized self-checking bench for sdram_cmd_scheduler
// Expected start cycles come from refresh-due arithmetic and the arbitration rules.
module tb_sdram_cmd_scheduler;
  localparam int IW  = 4;
  localparam int RI  = 20;
  localparam int NIR = 2;
  localparam int K_NONE = 0, K_PRE = 1, K_REF = 2, K_MRS = 3, K_RD = 4, K_WR = 5, K_MULTI = 6;

  logic clk = 1'b0, rst = 1'b1, rd_req = 1'b0, wr_req = 1'b0, seq_done = 1'b0;
  logic pre_start, ref_start, mrs_start, rd_start, wr_start;
  logic rd_ack, wr_ack, init_done, busy, ref_overrun;

  int cyc = 0, checks = 0, errors = 0;
  int r0, mrs_dn, s_ref, idle_from;
  bit last_rd_m;
  int ref_list[$];
  int exp_init[4] = '{K_PRE, K_REF, K_REF, K_MRS};
  int init_k[4], init_s[4], init_d[4];
  bit init_ack, init_clean, init_done_obs, busy_obs;

  sdram_cmd_scheduler #(.INIT_WAIT(IW), .REFRESH_INTERVAL(RI), .NUM_INIT_REF(NIR)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .seq_done(seq_done),
    .pre_start(pre_start), .ref_start(ref_start), .mrs_start(mrs_start),
    .rd_start(rd_start), .wr_start(wr_start), .rd_ack(rd_ack), .wr_ack(wr_ack),
    .init_done(init_done), .busy(busy), .ref_overrun(ref_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int decode();
    int n = int'(pre_start) + int'(ref_start) + int'(mrs_start) + int'(rd_start) + int'(wr_start);
    if (n > 1) return K_MULTI;
    if (pre_start) return K_PRE;
    if (ref_start) return K_REF;
    if (mrs_start) return K_MRS;
    if (rd_start)  return K_RD;
    if (wr_start)  return K_WR;
    return K_NONE;
  endfunction

  function automatic logic [9:0] outs();
    return {pre_start, ref_start, mrs_start, rd_start, wr_start, rd_ack, wr_ack, init_done, busy, ref_overrun};
  endfunction

  // refresh becomes due at mrs_dn+1+k*RI; first such cycle strictly after s
  function automatic int first_wrap(int s);
    int base = mrs_dn + 1;
    if (s < base + RI) return base + RI;
    return base + ((s - base) / RI + 1) * RI;
  endfunction

  // overrun: two consecutive due points with no refresh start clearing the first in time
  function automatic bit ovr_exp(int t);
    for (int w = mrs_dn + 1 + RI; w + RI <= t; w += RI) begin
      bit cleared = 0;
      foreach (ref_list[i]) if (ref_list[i] >= w && ref_list[i] <= w + RI - 2) cleared = 1;
      if (!cleared) return 1;
    end
    return 0;
  endfunction

  task automatic predict(input int i_cyc, input bit rd, input bit wr, output int kind, output int st);
    int w = first_wrap(s_ref);
    int t = (rd || wr) ? i_cyc : ((w > i_cyc) ? w : i_cyc);
    if (w <= t)        kind = K_REF;
    else if (rd && wr) kind = last_rd_m ? K_WR : K_RD;
    else               kind = rd ? K_RD : K_WR;
    st = t + 2;
  endtask

  task automatic commit(input int kind, input int st, input int dn);
    if (kind == K_REF) begin s_ref = st; ref_list.push_back(st); end
    if (kind == K_RD) last_rd_m = 1;
    if (kind == K_WR) last_rd_m = 0;
    idle_from = dn + 1;
  endtask

  task automatic wait_start(input int budget, output int kind, output int st);
    kind = K_NONE; st = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (decode() != K_NONE) begin kind = decode(); st = cyc; break; end
    end
  endtask

  task automatic finish_op(input int st, input int delay, input bit drop,
                           output int dn, output bit ack_r, output bit ack_w, output bit clean);
    clean = 1;
    for (int i = 1; i < delay; i++) begin
      @(negedge clk);
      if (decode() != K_NONE || rd_ack || wr_ack) clean = 0;
    end
    @(negedge clk);
    if (decode() != K_NONE || cyc != st + delay) clean = 0;
    seq_done = 1'b1;
    #1;
    ack_r = rd_ack; ack_w = wr_ack; dn = cyc;
    if (drop && ack_r) rd_req = 1'b0;
    if (drop && ack_w) wr_req = 1'b0;
    @(posedge clk);
    #1 seq_done = 1'b0;
  endtask

  task automatic drive_op(input int delay, input bit drop, output int kind, output int st,
                          output int dn, output bit ack_r, output bit ack_w, output bit clean);
    wait_start(100, kind, st);
    if (kind == K_NONE) begin dn = cyc; ack_r = 0; ack_w = 0; clean = 0; end
    else finish_op(st, delay, drop, dn, ack_r, ack_w, clean);
  endtask

  task automatic run_init();
    bit ar, aw, cl;
    init_ack = 0; init_clean = 1;
    for (int i = 0; i < 4; i++) begin
      wait_start(100, init_k[i], init_s[i]);
      if (init_k[i] == K_NONE) init_d[i] = cyc;
      else begin
        finish_op(init_s[i], 3, 0, init_d[i], ar, aw, cl);
        if (ar || aw) init_ack = 1;
        if (!cl) init_clean = 0;
      end
    end
    @(negedge clk);
    init_done_obs = init_done; busy_obs = busy;
    mrs_dn = init_d[3]; s_ref = mrs_dn; ref_list.delete(); last_rd_m = 0; idle_from = mrs_dn + 1;
  endtask

  task automatic sync_ref(output int k, output int ek, output int s, output int es);
    int dn; bit ar, aw, cl;
    predict(idle_from, 0, 0, ek, es);
    drive_op($urandom_range(1, 4), 1, k, s, dn, ar, aw, cl);
    commit(ek, es, dn);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== 10'b0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", outs()); end
    rst = 1'b0; r0 = cyc;
  endtask

  task automatic test_init();
    int k, s, dn, ek, es; bit ar, aw, cl;
    rd_req = 1'b1;
    run_init();
    for (int i = 0; i < 4; i++) begin
      es = (i == 0) ? r0 + IW + 1 : init_d[i-1] + 2;
      checks++;
      if (init_k[i] !== exp_init[i] || init_s[i] !== es) begin
        errors++; $display("FAIL init_step%0d: kind %0d at %0d, expected kind %0d at %0d", i, init_k[i], init_s[i], exp_init[i], es);
      end
    end
    checks++;
    if (init_ack !== 0 || init_clean !== 1) begin errors++; $display("FAIL init_clean: ack %0d clean %0d expected 0 1", init_ack, init_clean); end
    checks++;
    if (init_done_obs !== 1 || busy_obs !== 0) begin errors++; $display("FAIL init_done_busy: init_done %0d busy %0d expected 1 0", init_done_obs, busy_obs); end
    predict(idle_from, 1, 0, ek, es);
    drive_op(3, 1, k, s, dn, ar, aw, cl);
    checks++;
    if (k !== ek || s !== es || ar !== 1 || aw !== 0 || !cl) begin
      errors++; $display("FAIL first_read: kind %0d at %0d ack %0d%0d, expected kind %0d at %0d ack 10", k, s, ar, aw, ek, es);
    end
    commit(ek, es, dn);
  endtask

  task automatic test_refresh();
    int k, s, dn, ek, es; bit ar, aw, cl;
    for (int i = 0; i < 6; i++) begin
      predict(idle_from, 0, 0, ek, es);
      drive_op($urandom_range(1, 4), 1, k, s, dn, ar, aw, cl);
      checks++;
      if (k !== ek || s !== es || ar || aw || !cl) begin
        errors++; $display("FAIL refresh%0d: kind %0d at %0d ack %0d%0d, expected kind %0d at %0d", i, k, s, ar, aw, ek, es);
      end
      commit(ek, es, dn);
    end
    checks++;
    if (ref_overrun !== ovr_exp(cyc) || ref_overrun !== 1'b0) begin
      errors++; $display("FAIL refresh_overrun: got %0d expected 0", ref_overrun);
    end
  endtask

  task automatic test_back_to_back();
    int k, s, dn, ek, es; bit ar, aw, cl;
    sync_ref(k, ek, s, es);
    checks++;
    if (k !== ek || s !== es) begin errors++; $display("FAIL b2b_sync: kind %0d at %0d expected %0d at %0d", k, s, ek, es); end
    rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      predict(idle_from, 1, 1, ek, es);
      drive_op($urandom_range(1, 6), 0, k, s, dn, ar, aw, cl);
      checks++;
      if (k !== ek || s !== es || ar !== (ek == K_RD) || aw !== (ek == K_WR) || !cl) begin
        errors++; $display("FAIL b2b_op%0d: kind %0d at %0d ack %0d%0d clean %0d, expected kind %0d at %0d", i, k, s, ar, aw, cl, ek, es);
      end
      commit(ek, es, dn);
    end
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  task automatic test_ref_during_read();
    int k, s, dn, ek, es, w, guard; bit ar, aw, cl;
    guard = 0;
    do begin
      sync_ref(k, ek, s, es);
      checks++;
      if (k !== ek || s !== es) begin errors++; $display("FAIL rdr_sync: kind %0d at %0d expected %0d at %0d", k, s, ek, es); end
      guard++;
    end while (first_wrap(s_ref) - 8 < idle_from && guard < 4);
    w = first_wrap(s_ref);
    while (cyc < w - 8) @(negedge clk);
    rd_req = 1'b1;
    predict(cyc, 1, 0, ek, es);
    wait_start(100, k, s);
    wr_req = 1'b1;
    if (k != K_NONE) finish_op(s, 10, 1, dn, ar, aw, cl);
    else begin dn = cyc; ar = 0; aw = 0; end
    checks++;
    if (k !== ek || ek !== K_RD || s !== es || ar !== 1 || aw !== 0) begin
      errors++; $display("FAIL rdr_read: kind %0d at %0d ack %0d%0d, expected kind %0d at %0d", k, s, ar, aw, K_RD, es);
    end
    commit(ek, es, dn);
    predict(idle_from, 0, 1, ek, es);
    drive_op(2, 1, k, s, dn, ar, aw, cl);
    checks++;
    if (k !== K_REF || ek !== K_REF || s !== es || aw !== 0) begin
      errors++; $display("FAIL rdr_ref_first: kind %0d at %0d, expected kind %0d at %0d", k, s, K_REF, es);
    end
    commit(ek, es, dn);
    predict(idle_from, 0, 1, ek, es);
    drive_op(3, 1, k, s, dn, ar, aw, cl);
    checks++;
    if (k !== ek || s !== es || aw !== 1 || ar !== 0) begin
      errors++; $display("FAIL rdr_write: kind %0d at %0d ack %0d%0d, expected kind %0d at %0d", k, s, ar, aw, ek, es);
    end
    commit(ek, es, dn);
  endtask

  task automatic test_overrun();
    int k, s, dn, ek, es; bit ar, aw, cl;
    sync_ref(k, ek, s, es);
    checks++;
    if (k !== ek || s !== es) begin errors++; $display("FAIL ovr_sync: kind %0d at %0d expected %0d at %0d", k, s, ek, es); end
    rd_req = 1'b1;
    predict(idle_from, 1, 0, ek, es);
    drive_op(2 * RI + 5, 1, k, s, dn, ar, aw, cl);
    checks++;
    if (k !== ek || s !== es || ar !== 1) begin errors++; $display("FAIL ovr_read: kind %0d at %0d ack %0d, expected kind %0d at %0d", k, s, ar, ek, es); end
    commit(ek, es, dn);
    checks++;
    if (ref_overrun !== ovr_exp(cyc) || ref_overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0d expected 1", ref_overrun); end
    predict(idle_from, 0, 0, ek, es);
    drive_op(3, 1, k, s, dn, ar, aw, cl);
    checks++;
    if (k !== ek || ek !== K_REF || s !== es) begin errors++; $display("FAIL ovr_ref: kind %0d at %0d expected %0d at %0d", k, s, K_REF, es); end
    commit(ek, es, dn);
    checks++;
    if (ref_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0d expected 1", ref_overrun); end
  endtask

  task automatic test_reset_mid();
    int k, s, dn, ek, es; bit ar, aw, cl;
    rst = 1'b1;
    #1;
    repeat (2) @(negedge clk);
    rst = 1'b0; r0 = cyc;
    wait_start(100, k, s);
    checks++;
    if (k !== K_PRE || s !== r0 + IW + 1) begin errors++; $display("FAIL mid_pre: kind %0d at %0d expected %0d at %0d", k, s, K_PRE, r0 + IW + 1); end
    if (k != K_NONE) finish_op(s, 3, 0, dn, ar, aw, cl);
    wait_start(100, k, s);
    checks++;
    if (k !== K_REF) begin errors++; $display("FAIL mid_ref: kind %0d expected %0d", k, K_REF); end
    rst = 1'b1;
    #1;
    checks++;
    if (outs() !== 10'b0) begin errors++; $display("FAIL mid_init_reset: got %b expected 0", outs()); end
    repeat (2) @(negedge clk);
    rst = 1'b0; r0 = cyc;
    run_init();
    for (int i = 0; i < 4; i++) begin
      es = (i == 0) ? r0 + IW + 1 : init_d[i-1] + 2;
      checks++;
      if (init_k[i] !== exp_init[i] || init_s[i] !== es) begin
        errors++; $display("FAIL reinit1_step%0d: kind %0d at %0d, expected kind %0d at %0d", i, init_k[i], init_s[i], exp_init[i], es);
      end
    end
    wr_req = 1'b1;
    predict(idle_from, 0, 1, ek, es);
    wait_start(100, k, s);
    checks++;
    if (k !== ek || s !== es) begin errors++; $display("FAIL mid_write: kind %0d at %0d expected %0d at %0d", k, s, ek, es); end
    @(negedge clk);
    rst = 1'b1;
    seq_done = 1'b1;
    #1;
    checks++;
    if (outs() !== 10'b0) begin errors++; $display("FAIL mid_write_reset: got %b expected 0", outs()); end
    seq_done = 1'b0; wr_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0; r0 = cyc;
    run_init();
    for (int i = 0; i < 4; i++) begin
      es = (i == 0) ? r0 + IW + 1 : init_d[i-1] + 2;
      checks++;
      if (init_k[i] !== exp_init[i] || init_s[i] !== es) begin
        errors++; $display("FAIL reinit2_step%0d: kind %0d at %0d, expected kind %0d at %0d", i, init_k[i], init_s[i], exp_init[i], es);
      end
    end
    checks++;
    if (init_ack !== 0 || init_done_obs !== 1) begin errors++; $display("FAIL reinit2_ack: ack %0d init_done %0d expected 0 1", init_ack, init_done_obs); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_refresh();
    test_back_to_back();
    test_ref_during_read();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
